// File: rtl/pmci_vdm_mmio_tx_mux.sv
// Multi-channel MMIO-staged VDM/MCTP transmit buffer with round-robin drain onto one stream.
// Optional macro PMCI_VDM_TX_PKT_CNT_EN adds a per-channel completed-packet counter at CNT.
module pmci_vdm_mmio_tx_mux #(
    parameter logic [31:0] BASE_ADDR = 32'h2000,
    parameter int          NUM_CH    = 2,
    parameter int          DEPTH     = 64,
    parameter int          DATA_W    = 64,
    parameter int          ADDR_W    = 20,
    localparam int         CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              csr_wr_i,
    input  logic              csr_rd_i,
    input  logic [ADDR_W-1:0] csr_addr_i,
    input  logic [63:0]       csr_wdata_i,
    output logic [63:0]       csr_rdata_o,
    output logic              csr_rvalid_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_sop_o,
    output logic              tx_eop_o,
    output logic [CHW-1:0]    tx_ch_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t            state_q;
    logic [CHW-1:0]    grant_q;
    logic [CHW-1:0]    ptr_q;
    logic              tx_valid_q;
    logic              tx_sop_q;
    logic              csr_rvalid_q;
    logic [63:0]       csr_rdata_q;

    logic [31:0]       addr32;
    logic [31:0]       off;
    logic              hit;
    logic [2:0]        sel_ch;
    logic [1:0]        sel_reg;

    logic              req_w       [NUM_CH];
    logic [DATA_W-1:0] head_data_w [NUM_CH];
    logic              head_eop_w  [NUM_CH];
    logic [63:0]       reg_rdata_w [NUM_CH];

    logic              pick_found;
    logic [CHW-1:0]    pick_ch;
    logic [DATA_W-1:0] g_data;
    logic              g_eop;
    logic [63:0]       rd_val;

    assign addr32  = 32'(csr_addr_i);
    assign off     = addr32 - BASE_ADDR;
    assign hit     = (addr32 >= BASE_ADDR) && (off < 32'(NUM_CH * 32));
    assign sel_ch  = off[7:5];
    assign sel_reg = off[4:3];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam logic [2:0] CH = 3'(gi);

        logic              sel, fcr_wr, pdr_wr, granted, pop, pop_eop;
        logic              flush_req, flush_apply, commit, push, full;
        logic [PW-1:0]     wr_q, rd_q, cm_q, pkt_q, rd_d, wr_last, fill;
        logic              ovf_q, flush_pend_q;
        logic [DEPTH-1:0]  eop_q;
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] head_q;
        logic [31:0]       cnt_rd;
        logic [63:0]       fcr_rd;

        assign sel       = hit && (sel_ch == CH);
        assign fcr_wr    = csr_wr_i && sel && (sel_reg == 2'd0);
        assign pdr_wr    = csr_wr_i && sel && (sel_reg == 2'd1);
        assign granted   = (state_q == S_GRANT) && (grant_q == CHW'(gi));
        assign pop       = tx_valid_q && tx_ready_i && (grant_q == CHW'(gi));
        assign pop_eop   = pop && eop_q[rd_q[AW-1:0]];
        assign flush_req = fcr_wr && csr_wdata_i[3];
        // A flush aimed at the packet on the wire waits for its eop handshake.
        assign flush_apply = (flush_req && !granted) || (pop_eop && (flush_pend_q || flush_req));
        assign fill      = wr_q - rd_q;
        assign full      = (fill == PW'(DEPTH));
        assign push      = pdr_wr && !full;
        assign commit    = fcr_wr && csr_wdata_i[0] && (wr_q != cm_q) && !flush_apply;
        assign rd_d      = flush_apply ? wr_q : rd_q + PW'(pop);
        assign wr_last   = wr_q - PW'(1);

        // Head register re-reads every cycle so it always reflects the current read pointer.
        always_ff @(posedge clk_i) begin
            if (push) begin
                mem[wr_q[AW-1:0]] <= csr_wdata_i[DATA_W-1:0];
            end
            head_q <= mem[rd_d[AW-1:0]];
        end

        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                wr_q         <= '0;
                rd_q         <= '0;
                cm_q         <= '0;
                pkt_q        <= '0;
                ovf_q        <= 1'b0;
                flush_pend_q <= 1'b0;
                eop_q        <= '0;
            end else begin
                wr_q <= wr_q + PW'(push);
                rd_q <= rd_d;
                if (flush_apply) begin
                    cm_q  <= wr_q;
                    pkt_q <= '0;
                end else begin
                    if (commit) begin
                        cm_q <= wr_q;
                    end
                    pkt_q <= pkt_q + PW'(commit) - PW'(pop_eop);
                end
                ovf_q <= (ovf_q | (pdr_wr && full)) & !(fcr_wr && csr_wdata_i[1]);
                if (flush_apply) begin
                    flush_pend_q <= 1'b0;
                end else if (flush_req && granted) begin
                    flush_pend_q <= 1'b1;
                end
                if (push) begin
                    eop_q[wr_q[AW-1:0]] <= 1'b0;
                end
                if (commit) begin
                    eop_q[wr_last[AW-1:0]] <= 1'b1;
                end
            end
        end

`ifdef PMCI_VDM_TX_PKT_CNT_EN
        logic        cnt_wr;
        logic [31:0] cnt_q;
        assign cnt_wr = csr_wr_i && sel && (sel_reg == 2'd2);
        // A clear that coincides with a completion keeps that completion.
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                cnt_q <= '0;
            end else if (cnt_wr) begin
                cnt_q <= pop_eop ? 32'd1 : 32'd0;
            end else if (pop_eop) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
        assign cnt_rd = cnt_q;
`else
        assign cnt_rd = 32'd0;
`endif

        assign fcr_rd = {32'b0, 16'(fill), 13'b0, full, ovf_q, (pkt_q != '0)};
        assign reg_rdata_w[gi] = (sel_reg == 2'd0) ? fcr_rd :
                                 (sel_reg == 2'd2) ? {32'b0, cnt_rd} : 64'b0;
        assign req_w[gi]       = (pkt_q != '0) && !flush_req;
        assign head_data_w[gi] = head_q;
        assign head_eop_w[gi]  = eop_q[rd_q[AW-1:0]];
    end

    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!pick_found &&
                req_w[((int'(ptr_q) + i) >= NUM_CH) ? (int'(ptr_q) + i - NUM_CH) : (int'(ptr_q) + i)]) begin
                pick_found = 1'b1;
                pick_ch    = CHW'(((int'(ptr_q) + i) >= NUM_CH) ? (int'(ptr_q) + i - NUM_CH) : (int'(ptr_q) + i));
            end
        end
    end

    always_comb begin
        g_data = '0;
        g_eop  = 1'b0;
        rd_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_q == CHW'(c)) begin
                g_data = head_data_w[c];
                g_eop  = head_eop_w[c];
            end
            if (hit && (sel_ch == 3'(c))) begin
                rd_val = reg_rdata_w[c];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            ptr_q        <= '0;
            tx_valid_q   <= 1'b0;
            tx_sop_q     <= 1'b0;
            csr_rvalid_q <= 1'b0;
            csr_rdata_q  <= '0;
        end else begin
            csr_rvalid_q <= csr_rd_i;
            csr_rdata_q  <= csr_rd_i ? rd_val : 64'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_q    <= pick_ch;
                        tx_valid_q <= 1'b1;
                        tx_sop_q   <= 1'b1;
                        state_q    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (tx_valid_q && tx_ready_i) begin
                        tx_sop_q <= 1'b0;
                        if (g_eop) begin
                            tx_valid_q <= 1'b0;
                            ptr_q      <= (grant_q == CHW'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
                            state_q    <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign csr_rdata_o  = csr_rdata_q;
    assign csr_rvalid_o = csr_rvalid_q;
    assign tx_valid_o   = tx_valid_q;
    assign tx_sop_o     = tx_sop_q;
    assign tx_eop_o     = tx_valid_q & g_eop;
    assign tx_data_o    = tx_valid_q ? g_data : '0;
    assign tx_ch_o      = grant_q;
endmodule
